// File: rtl/i2c_sample_assembler.sv
// ---------------------------------------------------------------------------
// i2c_sample_assembler
//
// Builds fixed-width samples from the bytes an I2C master receives during a
// read transaction. Bytes arrive MSB first, are shifted into an accumulator,
// and the byte that completes the sample commits it to a one-entry output
// register with a valid/ready handshake. A short transaction, a restart in
// the middle of a sample, or an inter-byte gap that is too long drops the
// partial sample and raises a one-cycle error pulse.
//
// Parameters
//   NBYTES       bytes per sample, 1..4
//   TIMEOUT_CYC  idle cycles allowed between bytes before a timeout
//
// Ports
//   i_clk_48mhz     system clock, rising edge
//   i_ext_reset     synchronous reset, active low
//   i_xfer_start    one-cycle strobe at START of a read
//   i_byte_in       received byte, valid with i_byte_valid
//   i_byte_valid    one-cycle strobe, i_byte_in holds a new byte
//   i_xfer_done     one-cycle strobe at STOP
//   i_out_ready     consumer takes o_out_data this cycle
//   o_out_data      assembled sample, right-justified, upper bits zero
//   o_out_valid     o_out_data holds an unconsumed sample
//   o_sample_count  samples committed since reset, wraps silently
//   o_err_short     pulse: transaction ended before NBYTES bytes
//   o_err_timeout   pulse: inter-byte gap reached TIMEOUT_CYC
//   o_overrun       pulse: an unconsumed sample was overwritten
//
// State  | meaning
// IDLE   | waiting for START, bytes and STOP ignored
// COLLECT| accumulating bytes of one sample
// ---------------------------------------------------------------------------
module i2c_sample_assembler #(
  parameter int NBYTES      = 3,
  parameter int TIMEOUT_CYC = 48000
) (
  input  logic        i_clk_48mhz,
  input  logic        i_ext_reset,
  input  logic        i_xfer_start,
  input  logic [7:0]  i_byte_in,
  input  logic        i_byte_valid,
  input  logic        i_xfer_done,
  input  logic        i_out_ready,
  output logic [31:0] o_out_data,
  output logic        o_out_valid,
  output logic [15:0] o_sample_count,
  output logic        o_err_short,
  output logic        o_err_timeout,
  output logic        o_overrun
);

  localparam int              TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [2:0]      LP_NB  = 3'(NBYTES);
  localparam logic [TW-1:0]   LP_TMO = TW'(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_COLLECT} state_t;

  state_t        r_state;
  logic [31:0]   r_acc;
  logic [2:0]    r_byte_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic [31:0]   r_out_data;
  logic          r_out_valid;
  logic [15:0]   r_sample_count;
  logic          r_err_short;
  logic          r_err_timeout;
  logic          r_overrun;

  state_t        w_state_nxt;
  logic [31:0]   w_acc_nxt;
  logic [2:0]    w_cnt_nxt;
  logic [TW-1:0] w_tmo_nxt;
  logic [31:0]   w_out_data_nxt;
  logic          w_out_valid_nxt;
  logic [15:0]   w_count_nxt;
  logic          w_short_nxt;
  logic          w_timeout_nxt;
  logic          w_overrun_nxt;
  logic          w_commit;
  logic [31:0]   w_acc_shift;
  logic [2:0]    w_cnt_inc;
  logic [TW-1:0] w_tmo_inc;

  // Accumulator is cleared at START, so after NBYTES shifts the bits above
  // the sample are still zero and the result is already right-justified.
  assign w_acc_shift = {r_acc[23:0], i_byte_in};
  assign w_cnt_inc   = r_byte_cnt + 3'd1;
  assign w_tmo_inc   = r_tmo_cnt + TW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_cnt_nxt     = r_byte_cnt;
    w_tmo_nxt     = r_tmo_cnt;
    w_commit      = 1'b0;
    w_short_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_xfer_start) begin
          w_state_nxt = S_COLLECT;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
        end
      end

      S_COLLECT: begin
        if (i_byte_valid) begin
          // The byte is handled before a coincident STOP, and always beats
          // a timeout landing on the same cycle.
          w_acc_nxt = w_acc_shift;
          w_cnt_nxt = w_cnt_inc;
          w_tmo_nxt = '0;
          if (w_cnt_inc == LP_NB) begin
            w_commit    = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (i_xfer_done) begin
            w_short_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (i_xfer_start) begin
          // Repeated START mid-sample: drop the partial data, start over.
          w_short_nxt = 1'b1;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_tmo_nxt   = '0;
        end else if (i_xfer_done) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_inc == LP_TMO) begin
          w_timeout_nxt = 1'b1;
          w_tmo_nxt     = '0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_count_nxt     = r_sample_count;
    w_overrun_nxt   = 1'b0;
    if (w_commit) begin
      w_out_data_nxt  = w_acc_shift;
      w_out_valid_nxt = 1'b1;
      w_count_nxt     = r_sample_count + 16'd1;
      // A sample taken this very cycle is not lost, so no overrun then.
      w_overrun_nxt   = r_out_valid & ~i_out_ready;
    end else if (r_out_valid && i_out_ready) begin
      w_out_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge i_clk_48mhz) begin
    if (!i_ext_reset) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_byte_cnt     <= '0;
      r_tmo_cnt      <= '0;
      r_out_data     <= '0;
      r_out_valid    <= 1'b0;
      r_sample_count <= '0;
      r_err_short    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_overrun      <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_acc          <= w_acc_nxt;
      r_byte_cnt     <= w_cnt_nxt;
      r_tmo_cnt      <= w_tmo_nxt;
      r_out_data     <= w_out_data_nxt;
      r_out_valid    <= w_out_valid_nxt;
      r_sample_count <= w_count_nxt;
      r_err_short    <= w_short_nxt;
      r_err_timeout  <= w_timeout_nxt;
      r_overrun      <= w_overrun_nxt;
    end
  end

  assign o_out_data     = r_out_data;
  assign o_out_valid    = r_out_valid;
  assign o_sample_count = r_sample_count;
  assign o_err_short    = r_err_short;
  assign o_err_timeout  = r_err_timeout;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_i2c_sample_assembler.sv
// ---------------------------------------------------------------------------
// tb_i2c_sample_assembler
//
// Directed bench for i2c_sample_assembler with default parameters
// (3-byte samples, 48000-cycle timeout). Expected samples are queued when
// their final byte is driven and compared when the sample count advances.
// ---------------------------------------------------------------------------
module tb_i2c_sample_assembler;

  localparam int NB = 3;
  localparam int TMO = 48000;

  logic        clk;
  logic        i_ext_reset;
  logic        i_xfer_start;
  logic [7:0]  i_byte_in;
  logic        i_byte_valid;
  logic        i_xfer_done;
  logic        i_out_ready;
  logic [31:0] o_out_data;
  logic        o_out_valid;
  logic [15:0] o_sample_count;
  logic        o_err_short;
  logic        o_err_timeout;
  logic        o_overrun;

  int checks = 0;
  int failures = 0;
  int n_short = 0;
  int n_timeout = 0;
  int n_overrun = 0;
  int sb_commits = 0;
  logic [15:0] sb_prev_cnt = 16'd0;
  logic [31:0] sb_q[$];

  i2c_sample_assembler #(.NBYTES(NB), .TIMEOUT_CYC(TMO)) dut (
    .i_clk_48mhz    (clk),
    .i_ext_reset    (i_ext_reset),
    .i_xfer_start   (i_xfer_start),
    .i_byte_in      (i_byte_in),
    .i_byte_valid   (i_byte_valid),
    .i_xfer_done    (i_xfer_done),
    .i_out_ready    (i_out_ready),
    .o_out_data     (o_out_data),
    .o_out_valid    (o_out_valid),
    .o_sample_count (o_sample_count),
    .o_err_short    (o_err_short),
    .o_err_timeout  (o_err_timeout),
    .o_overrun      (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge. Outside reset the
  // scoreboard pops an expected sample whenever the sample count moves.
  task automatic step();
    logic [31:0] exp_data;
    @(posedge clk);
    #1;
    if (i_ext_reset) begin
      n_short   += int'(o_err_short);
      n_timeout += int'(o_err_timeout);
      n_overrun += int'(o_overrun);
      if (o_sample_count !== sb_prev_cnt) begin
        sb_prev_cnt = o_sample_count;
        exp_data = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
        sb_commits++;
        chk("sb_data", o_out_data, exp_data);
        chk("sb_count", 32'(o_sample_count), 32'(sb_commits));
      end
    end
  endtask

  // START, then the low nb bytes of data MSB first on consecutive cycles.
  // Optional STOP and/or ready on the last byte.
  task automatic xfer(input logic [31:0] data, input int nb, input bit done_last,
                      input bit rdy_last);
    i_xfer_start = 1'b1;
    step();
    i_xfer_start = 1'b0;
    for (int i = nb - 1; i >= 0; i--) begin
      i_byte_in    = data[i*8 +: 8];
      i_byte_valid = 1'b1;
      if (i == 0) begin
        if (done_last) i_xfer_done = 1'b1;
        if (rdy_last)  i_out_ready = 1'b1;
        if (nb == NB)  sb_q.push_back(data & 32'h00FF_FFFF);
      end
      step();
      i_byte_valid = 1'b0;
      i_xfer_done  = 1'b0;
      if (i == 0 && rdy_last) i_out_ready = 1'b0;
    end
  endtask

  initial begin
    int gap;
    bit found;

    i_ext_reset  = 1'b0;
    i_xfer_start = 1'b0;
    i_byte_in    = 8'h00;
    i_byte_valid = 1'b0;
    i_xfer_done  = 1'b0;
    i_out_ready  = 1'b0;
    repeat (3) step();

    chk("rst_data",    o_out_data, 32'h0);
    chk("rst_valid",   32'(o_out_valid), 32'd0);
    chk("rst_count",   32'(o_sample_count), 32'd0);
    chk("rst_short",   32'(o_err_short), 32'd0);
    chk("rst_timeout", 32'(o_err_timeout), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    i_ext_reset = 1'b1;
    step();

    // Basic 3-byte sample, consumer ready
    i_out_ready = 1'b1;
    xfer(32'h0012_3456, 3, 1'b0, 1'b0);
    chk("basic_valid_hi", 32'(o_out_valid), 32'd1);
    chk("basic_data", o_out_data, 32'h0012_3456);
    step();
    chk("basic_valid_1cyc", 32'(o_out_valid), 32'd0);
    chk("basic_count", 32'(o_sample_count), 32'd1);

    // Short transaction
    xfer(32'h0000_AABB, 2, 1'b0, 1'b0);
    i_xfer_done = 1'b1;
    step();
    i_xfer_done = 1'b0;
    chk("short_pulse", 32'(o_err_short), 32'd1);
    chk("short_valid", 32'(o_out_valid), 32'd0);
    chk("short_count", 32'(o_sample_count), 32'd1);
    step();
    chk("short_pulse_1cyc", 32'(o_err_short), 32'd0);

    // Byte and STOP after commit are ignored
    xfer(32'h0011_1213, 3, 1'b0, 1'b0);
    i_byte_in    = 8'h99;
    i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
    i_xfer_done  = 1'b1;
    step();
    i_xfer_done  = 1'b0;
    chk("post_commit_count", 32'(o_sample_count), 32'd2);
    chk("post_commit_data", o_out_data, 32'h0011_1213);
    chk("done_in_idle_short", 32'(o_err_short), 32'd0);

    // Last byte coincident with STOP commits without error
    xfer(32'h0021_2223, 3, 1'b1, 1'b0);
    chk("coinc_short", 32'(o_err_short), 32'd0);
    chk("coinc_count", 32'(o_sample_count), 32'd3);

    // Repeated START mid-sample restarts collection
    i_xfer_start = 1'b1;
    step();
    i_xfer_start = 1'b0;
    i_byte_in    = 8'h55;
    i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
    xfer(32'h0031_3233, 3, 1'b0, 1'b0);
    chk("restart_short_total", 32'(n_short), 32'd2);
    chk("restart_count", 32'(o_sample_count), 32'd4);
    step();

    // Overrun with consumer stalled
    i_out_ready = 1'b0;
    xfer(32'h0001_0203, 3, 1'b0, 1'b0);
    chk("ovr_first_none", 32'(o_overrun), 32'd0);
    xfer(32'h0004_0506, 3, 1'b0, 1'b0);
    chk("ovr_pulse", 32'(o_overrun), 32'd1);
    chk("ovr_valid", 32'(o_out_valid), 32'd1);
    chk("ovr_count", 32'(o_sample_count), 32'd6);
    repeat (5) step();
    chk("hold_data", o_out_data, 32'h0004_0506);
    chk("hold_valid", 32'(o_out_valid), 32'd1);
    chk("ovr_pulse_1cyc", 32'(o_overrun), 32'd0);
    i_out_ready = 1'b1;
    step();
    chk("consume_valid", 32'(o_out_valid), 32'd0);
    step();
    chk("ready_noeffect_valid", 32'(o_out_valid), 32'd0);
    chk("ready_noeffect_data", o_out_data, 32'h0004_0506);

    // Commit on the same cycle the old sample is taken
    i_out_ready = 1'b0;
    xfer(32'h0041_4243, 3, 1'b0, 1'b0);
    xfer(32'h0051_5253, 3, 1'b0, 1'b1);
    chk("same_cyc_overrun", 32'(o_overrun), 32'd0);
    chk("same_cyc_valid", 32'(o_out_valid), 32'd1);
    chk("same_cyc_count", 32'(o_sample_count), 32'd8);
    i_out_ready = 1'b1;
    step();

    // Inter-byte timeout
    xfer(32'h0000_0001, 1, 1'b0, 1'b0);
    gap = 0;
    found = 1'b0;
    for (int k = 1; k <= TMO + 10 && !found; k++) begin
      step();
      if (o_err_timeout === 1'b1) begin
        found = 1'b1;
        gap = k;
      end
    end
    chk("timeout_gap", 32'(gap), 32'(TMO));
    step();
    chk("timeout_pulse_1cyc", 32'(o_err_timeout), 32'd0);
    xfer(32'h0061_6263, 3, 1'b0, 1'b0);
    chk("after_timeout_count", 32'(o_sample_count), 32'd9);
    step();

    // Reset in the middle of a sample, inputs toggling during reset
    xfer(32'h0000_7172, 2, 1'b0, 1'b0);
    chk("pre_reset_queue_empty", 32'(sb_q.size()), 32'd0);
    i_ext_reset  = 1'b0;
    i_xfer_start = 1'b1;
    i_byte_valid = 1'b1;
    i_byte_in    = 8'hFF;
    i_xfer_done  = 1'b1;
    repeat (2) step();
    chk("mid_rst_data", o_out_data, 32'h0);
    chk("mid_rst_count", 32'(o_sample_count), 32'd0);
    chk("mid_rst_short", 32'(o_err_short), 32'd0);
    i_xfer_start = 1'b0;
    i_byte_valid = 1'b0;
    i_xfer_done  = 1'b0;
    i_ext_reset  = 1'b1;
    sb_prev_cnt  = 16'd0;
    sb_commits   = 0;
    step();
    // Stray byte in IDLE after reset must not count toward the next sample
    i_byte_in    = 8'h77;
    i_byte_valid = 1'b1;
    step();
    i_byte_valid = 1'b0;
    xfer(32'h000A_0B0C, 3, 1'b0, 1'b0);
    chk("post_rst_data", o_out_data, 32'h000A_0B0C);
    chk("post_rst_count", 32'(o_sample_count), 32'd1);
    step();

    chk("total_short", 32'(n_short), 32'd2);
    chk("total_timeout", 32'(n_timeout), 32'd1);
    chk("total_overrun", 32'(n_overrun), 32'd1);
    chk("final_queue_empty", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_sample_assembler.md
I2C_SAMPLE_ASSEMBLER -- requirements
Module: i2c_sample_assembler

Interface
REQ-001 Parameter NBYTES, default 3: bytes per sample, legal range 1..4.
REQ-002 Parameter TIMEOUT_CYC, default 48000: maximum idle cycles between bytes, 1 ms at 48 MHz.
REQ-003 CLK_48MHZ  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 EXT_RESET  in  1  reset, synchronous and active-low.
REQ-005 XFER_START  in  1  one-cycle strobe from the I2C master at START of a read transaction.
REQ-006 BYTE_IN  in  8  received data byte; valid only while BYTE_VALID=1.
REQ-007 BYTE_VALID  in  1  one-cycle strobe; BYTE_IN holds a new byte.
REQ-008 XFER_DONE  in  1  one-cycle strobe from the I2C master at STOP.
REQ-009 OUT_READY  in  1  downstream consumer accepts OUT_DATA this cycle.
REQ-010 OUT_DATA  out  32  assembled sample, right-justified, upper unused bits zero.
REQ-011 OUT_VALID  out  1  OUT_DATA holds an unconsumed sample.
REQ-012 SAMPLE_COUNT  out  16  number of samples committed since reset.
REQ-013 ERR_SHORT  out  1  one-cycle pulse: transaction ended with fewer than NBYTES bytes.
REQ-014 ERR_TIMEOUT  out  1  one-cycle pulse: inter-byte gap reached TIMEOUT_CYC.
REQ-015 OVERRUN  out  1  one-cycle pulse: an unconsumed sample was overwritten.

Function
REQ-016 FSM states SHALL be IDLE and COLLECT.
REQ-017 IDLE: on XFER_START -> COLLECT; clear accumulator, byte counter and timeout counter; ignore BYTE_VALID and XFER_DONE.
REQ-018 COLLECT, on BYTE_VALID: acc <= (acc << 8) | BYTE_IN, MSB first; byte counter +1; timeout counter cleared.
REQ-019 The byte that brings the counter to NBYTES SHALL commit acc into OUT_DATA on the next edge, one cycle latency, set OUT_VALID, increment SAMPLE_COUNT and return the FSM to IDLE.
REQ-020 Bytes after commit and before the next XFER_START SHALL be ignored.
REQ-021 COLLECT, on XFER_DONE with counter < NBYTES: pulse ERR_SHORT, discard the partial sample, -> IDLE.
REQ-022 BYTE_VALID and XFER_DONE in the same cycle: the byte SHALL be processed first; if it completes the sample, commit with no ERR_SHORT, otherwise ERR_SHORT.
REQ-023 COLLECT, on XFER_START without BYTE_VALID: pulse ERR_SHORT, clear counters and accumulator, remain in COLLECT.
REQ-024 COLLECT, timeout counter increments each cycle with no BYTE_VALID; on reaching TIMEOUT_CYC: pulse ERR_TIMEOUT, discard, -> IDLE.
REQ-025 Timeout and BYTE_VALID in the same cycle: the byte wins and there is no timeout.
REQ-026 OUT_VALID SHALL stay 1 with OUT_DATA stable until a cycle with OUT_READY=1, then clear next edge unless a commit occurs that same cycle.
REQ-027 Commit while OUT_VALID=1 and OUT_READY=0: overwrite OUT_DATA, pulse OVERRUN, OUT_VALID stays 1.
REQ-028 Commit in the same cycle as OUT_READY=1: no OVERRUN; new data presented; OUT_VALID stays 1.
REQ-029 SAMPLE_COUNT SHALL wrap 0xFFFF -> 0x0000 with no flag.
REQ-030 OUT_READY while OUT_VALID=0 SHALL have no effect.

Reset
REQ-031 EXT_RESET=0 at a clock edge SHALL force: FSM IDLE; OUT_DATA=0, OUT_VALID=0, SAMPLE_COUNT=0, ERR_SHORT=0, ERR_TIMEOUT=0, OVERRUN=0; all counters and the accumulator cleared.
REQ-032 Reset asserted mid-COLLECT SHALL discard the partial sample with no error pulse.
REQ-033 All inputs SHALL be ignored while EXT_RESET=0.

Verification
REQ-034 NBYTES=3: START, bytes 0x12,0x34,0x56, OUT_READY=1 -> OUT_DATA=0x00123456, OUT_VALID high 1 cycle, SAMPLE_COUNT=1.
REQ-035 START, bytes 0xAA,0xBB, then DONE -> ERR_SHORT pulse, OUT_VALID stays 0, SAMPLE_COUNT=0.
REQ-036 START, byte 0x01, then 48000 idle cycles -> ERR_TIMEOUT pulse at gap cycle 48000; a following START plus 3 bytes commits normally.
REQ-037 OUT_READY=0; two full transactions 0x010203 and 0x040506 -> OVERRUN pulse on the second commit, OUT_DATA=0x00040506, SAMPLE_COUNT=2.
REQ-038 Third byte coincident with XFER_DONE -> commit, no ERR_SHORT.
REQ-039 Reset after 2 bytes, then START plus 3 bytes 0x0A,0x0B,0x0C -> OUT_DATA=0x000A0B0C, no error pulses.
